// File: rtl/spi_reg_responder.sv
// SPI mode-0 register slave: header {rw, addr} followed by an auto-incrementing data burst,
// with all pads oversampled in the clk domain and a registered local read port.
module spi_reg_responder #(
  parameter int         ADDR_W    = 4,
  parameter logic [7:0] ID_BYTE   = 8'hA5,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spck,
  input  logic              ncs,
  input  logic              mosi,
  output logic              miso,
  input  logic [ADDR_W-1:0] host_addr,
  output logic [7:0]        host_rdata,
  output logic              wr_tick,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              frame_done
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t            state;
  logic [1:0]        spck_sync;
  logic [1:0]        ncs_sync;
  logic [1:0]        mosi_sync;
  logic              spck_d;
  logic              ncs_d;
  logic [6:0]        rx_shreg;
  logic [7:0]        tx_shreg;
  logic [2:0]        bit_cnt;
  logic              byte_done;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic              wr_pend;
  logic [7:0]        regfile [DEPTH];

  logic       spck_rise;
  logic       spck_fall;
  logic       ncs_fall;
  logic [7:0] rx_byte;

  // ncs synchroniser resets low so a frame already running at reset release never looks like a new start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spck_sync <= 2'b00;
      ncs_sync  <= 2'b00;
      mosi_sync <= 2'b00;
      spck_d    <= 1'b0;
      ncs_d     <= 1'b0;
    end else begin
      spck_sync <= {spck_sync[0], spck};
      ncs_sync  <= {ncs_sync[0], ncs};
      mosi_sync <= {mosi_sync[0], mosi};
      spck_d    <= spck_sync[1];
      ncs_d     <= ncs_sync[1];
    end
  end

  assign spck_rise = spck_sync[1] & ~spck_d;
  assign spck_fall = ~spck_sync[1] & spck_d;
  assign ncs_fall  = ncs_d & ~ncs_sync[1];
  assign rx_byte   = {rx_shreg, mosi_sync[1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      miso       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      wr_tick    <= 1'b0;
      wr_pend    <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 8'h00;
      rx_shreg   <= 7'h00;
      tx_shreg   <= 8'h00;
      bit_cnt    <= 3'd0;
      byte_done  <= 1'b0;
      rw         <= 1'b0;
      addr       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regfile[i] <= RESET_VAL;
      end
    end else begin
      wr_tick    <= wr_pend;
      wr_pend    <= 1'b0;
      frame_done <= 1'b0;
      if (ncs_sync[1]) begin
        if (state != IDLE) begin
          frame_done <= 1'b1;
        end
        state     <= IDLE;
        busy      <= 1'b0;
        miso      <= 1'b0;
        bit_cnt   <= 3'd0;
        byte_done <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (ncs_fall) begin
              state     <= HDR;
              busy      <= 1'b1;
              tx_shreg  <= ID_BYTE;
              miso      <= ID_BYTE[7];
              bit_cnt   <= 3'd0;
              byte_done <= 1'b0;
            end
          end
          HDR, DATA: begin
            if (spck_rise) begin
              rx_shreg <= rx_byte[6:0];
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                byte_done <= 1'b1;
                if (state == HDR) begin
                  rw    <= rx_byte[7];
                  addr  <= rx_byte[ADDR_W-1:0];
                  state <= DATA;
                end else if (!rw) begin
                  regfile[addr] <= rx_byte;
                  wr_addr       <= addr;
                  wr_data       <= rx_byte;
                  wr_pend       <= 1'b1;
                  addr          <= addr + 1'b1;
                end
              end
            end else if (spck_fall) begin
              // The falling edge after a completed byte starts the next outgoing byte
              if (byte_done) begin
                byte_done <= 1'b0;
                if (rw) begin
                  tx_shreg <= regfile[addr];
                  miso     <= regfile[addr][7];
                  addr     <= addr + 1'b1;
                end else begin
                  tx_shreg <= 8'h00;
                  miso     <= 1'b0;
                end
              end else begin
                tx_shreg <= {tx_shreg[6:0], 1'b0};
                miso     <= tx_shreg[6];
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      host_rdata <= 8'h00;
    end else begin
      host_rdata <= regfile[host_addr];
    end
  end

endmodule
